// File: rtl/inorder_deq_policy_pkg.sv
// Shared sizes and FSM encodings for the in-order queue dequeue policy.
// Imported by the dequeue policy top and its one-hot decoder.
package inorder_deq_policy_pkg;

  localparam int DEQ_QUEUE_SIZE     = 8;
  localparam int DEQ_QUEUE_SIZE_LOG = 3;

  typedef enum logic [1:0] {
    DEQ_IDLE = 2'd0,
    DEQ_REQ  = 2'd1,
    DEQ_WAIT = 2'd2
  } deq_state_e;

endpackage

// File: rtl/inorder_deq_policy_ptr_to_onehot.sv
// Queue index to one-hot decoder, shared by enqueue and dequeue sides.
// Ports: idx (index, LOG bits) -> oh (N-bit one-hot).
module inorder_deq_policy_ptr_to_onehot
  import inorder_deq_policy_pkg::*;
#(
  parameter int N   = DEQ_QUEUE_SIZE,
  parameter int LOG = DEQ_QUEUE_SIZE_LOG
) (
  input  logic [LOG-1:0] idx,
  output logic [N-1:0]   oh
);

  always_comb begin
    oh      = '0;
    oh[idx] = 1'b1;
  end

endmodule

// File: rtl/inorder_deq_policy.sv
// Dequeue pointer policy: drains committed head entries via req/resp.
// Ports: clock/reset, enq_ptr, head handshake, deq_ptr(+oh), empty/full/count.
module inorder_deq_policy
  import inorder_deq_policy_pkg::*;
#(
  parameter int QUEUE_SIZE     = DEQ_QUEUE_SIZE,
  parameter int QUEUE_SIZE_LOG = DEQ_QUEUE_SIZE_LOG
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [QUEUE_SIZE_LOG:0] enq_ptr,
  input  logic                    head_commit_valid,
  output logic                    head_req_valid,
  input  logic                    head_req_ready,
  input  logic                    head_resp_valid,
  output logic                    deq_fire,
  output logic [QUEUE_SIZE_LOG:0] deq_ptr,
  output logic [QUEUE_SIZE-1:0]   deq_ptr_oh,
  output logic                    empty,
  output logic                    full,
  output logic [QUEUE_SIZE_LOG:0] count
);

  localparam int MSB = QUEUE_SIZE_LOG;

  deq_state_e              state_q;
  deq_state_e              state_d;
  logic [QUEUE_SIZE_LOG:0] ptr_q;

  // Status follows enq_ptr combinationally so a flush rewind
  // shows up in the same cycle.
  assign deq_ptr = ptr_q;
  assign empty   = (enq_ptr == ptr_q);
  assign full    = (enq_ptr[MSB] != ptr_q[MSB]) &&
                   (enq_ptr[MSB-1:0] == ptr_q[MSB-1:0]);
  assign count   = enq_ptr - ptr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DEQ_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (deq_fire) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    head_req_valid = 1'b0;
    deq_fire       = 1'b0;
    unique case (state_q)
      DEQ_IDLE: begin
        if (!empty && head_commit_valid) begin
          state_d = DEQ_REQ;
        end
      end
      DEQ_REQ: begin
        head_req_valid = 1'b1;
        if (head_req_ready) begin
          state_d = DEQ_WAIT;
        end
      end
      DEQ_WAIT: begin
        if (head_resp_valid) begin
          deq_fire = 1'b1;
          state_d  = DEQ_IDLE;
        end
      end
      default: begin
        state_d = DEQ_IDLE;
      end
    endcase
  end

  inorder_deq_policy_ptr_to_onehot #(
    .N   (QUEUE_SIZE),
    .LOG (QUEUE_SIZE_LOG)
  ) u_oh (
    .idx (ptr_q[MSB-1:0]),
    .oh  (deq_ptr_oh)
  );

endmodule

// File: tb/tb_inorder_deq_policy.sv
// Directed bench for inorder_deq_policy (QUEUE_SIZE=8).
// Drives on the falling edge, checks 1ns later.
module tb_inorder_deq_policy;

  logic       clock;
  logic       reset;
  logic [3:0] enq_ptr;
  logic       head_commit_valid;
  logic       head_req_valid;
  logic       head_req_ready;
  logic       head_resp_valid;
  logic       deq_fire;
  logic [3:0] deq_ptr;
  logic [7:0] deq_ptr_oh;
  logic       empty;
  logic       full;
  logic [3:0] count;

  int tests;
  int fails;

  inorder_deq_policy dut (
    .clock             (clock),
    .reset             (reset),
    .enq_ptr           (enq_ptr),
    .head_commit_valid (head_commit_valid),
    .head_req_valid    (head_req_valid),
    .head_req_ready    (head_req_ready),
    .head_resp_valid   (head_resp_valid),
    .deq_fire          (deq_fire),
    .deq_ptr           (deq_ptr),
    .deq_ptr_oh        (deq_ptr_oh),
    .empty             (empty),
    .full              (full),
    .count             (count)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset             = 1'b1;
    enq_ptr           = 4'd0;
    head_commit_valid = 1'b0;
    head_req_ready    = 1'b0;
    head_resp_valid   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset   = 1'b1;
    enq_ptr = 4'd0;
    #1;
    tests++;
    if ({deq_ptr, deq_ptr_oh, empty, full, count, head_req_valid, deq_fire}
        !== {4'd0, 8'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: ptr=%0d oh=%b e=%b f=%b cnt=%0d req=%b fire=%b",
               deq_ptr, deq_ptr_oh, empty, full, count,
               head_req_valid, deq_fire);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_drain();
    do_reset();
    @(negedge clock);
    enq_ptr           = 4'd1;
    head_commit_valid = 1'b1;
    head_req_ready    = 1'b1;
    #1;
    tests++;
    if ({head_req_valid, count, empty} !== {1'b0, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL single_c0: req=%b cnt=%0d empty=%b want 0 1 0",
               head_req_valid, count, empty);
    end
    @(negedge clock);
    #1;
    tests++;
    if ({head_req_valid, deq_fire} !== 2'b10) begin
      fails++;
      $display("FAIL single_c1: req=%b fire=%b want 1 0",
               head_req_valid, deq_fire);
    end
    @(negedge clock);
    #1;
    tests++;
    if ({head_req_valid, deq_fire} !== 2'b00) begin
      fails++;
      $display("FAIL single_c2: req=%b fire=%b want 0 0",
               head_req_valid, deq_fire);
    end
    @(negedge clock);
    head_resp_valid = 1'b1;
    #1;
    tests++;
    if (deq_fire !== 1'b1 || deq_ptr !== 4'd0) begin
      fails++;
      $display("FAIL single_c3: fire=%b ptr=%0d want 1 0",
               deq_fire, deq_ptr);
    end
    @(negedge clock);
    head_resp_valid = 1'b0;
    #1;
    tests++;
    if ({deq_ptr, empty, deq_fire, deq_ptr_oh} !==
        {4'd1, 1'b1, 1'b0, 8'b10}) begin
      fails++;
      $display("FAIL single_after: ptr=%0d empty=%b fire=%b oh=%b",
               deq_ptr, empty, deq_fire, deq_ptr_oh);
    end
    @(negedge clock);
    #1;
    tests++;
    if (head_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_idle_empty: req=%b want 0", head_req_valid);
    end
  endtask

  task automatic test_wrap_full();
    int fires;
    fires = 0;
    do_reset();
    @(negedge clock);
    enq_ptr = 4'b1000;
    #1;
    tests++;
    if ({full, empty, count} !== {1'b1, 1'b0, 4'd8}) begin
      fails++;
      $display("FAIL wrap_full: f=%b e=%b cnt=%0d want 1 0 8",
               full, empty, count);
    end
    head_commit_valid = 1'b1;
    head_req_ready    = 1'b1;
    head_resp_valid   = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i != 0) @(negedge clock);
      #1;
      if (deq_fire) fires++;
      if (i == 2) begin
        tests++;
        if ({deq_fire, full} !== 2'b11) begin
          fails++;
          $display("FAIL wrap_fire_full: fire=%b full=%b want 1 1",
                   deq_fire, full);
        end
      end
      if (i == 3) begin
        tests++;
        if ({full, count} !== {1'b0, 4'd7}) begin
          fails++;
          $display("FAIL wrap_full_drop: full=%b cnt=%0d want 0 7",
                   full, count);
        end
      end
    end
    @(negedge clock);
    head_commit_valid = 1'b0;
    #1;
    tests++;
    if (fires != 8) begin
      fails++;
      $display("FAIL wrap_fires: got %0d want 8", fires);
    end
    tests++;
    if ({deq_ptr, empty, full, deq_ptr_oh} !==
        {4'b1000, 1'b1, 1'b0, 8'b1}) begin
      fails++;
      $display("FAIL wrap_end: ptr=%b e=%b f=%b oh=%b",
               deq_ptr, empty, full, deq_ptr_oh);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clock);
    enq_ptr           = 4'd1;
    head_commit_valid = 1'b1;
    head_req_ready    = 1'b0;
    head_resp_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      #1;
      tests++;
      if ({head_req_valid, deq_fire, count} !== {1'b1, 1'b0, 4'd1}) begin
        fails++;
        $display("FAIL bp_hold%0d: req=%b fire=%b cnt=%0d want 1 0 1",
                 i, head_req_valid, deq_fire, count);
      end
    end
    @(negedge clock);
    head_req_ready = 1'b1;
    #1;
    tests++;
    if ({head_req_valid, deq_fire} !== 2'b10) begin
      fails++;
      $display("FAIL bp_accept: req=%b fire=%b want 1 0",
               head_req_valid, deq_fire);
    end
    @(negedge clock);
    head_req_ready = 1'b0;
    #1;
    tests++;
    if ({deq_fire, head_req_valid} !== 2'b10) begin
      fails++;
      $display("FAIL bp_fire: fire=%b req=%b want 1 0",
               deq_fire, head_req_valid);
    end
    @(negedge clock);
    head_resp_valid = 1'b0;
    #1;
    tests++;
    if ({deq_ptr, count, empty} !== {4'd1, 4'd0, 1'b1}) begin
      fails++;
      $display("FAIL bp_end: ptr=%0d cnt=%0d e=%b want 1 0 1",
               deq_ptr, count, empty);
    end
  endtask

  task automatic test_overlap_flush();
    do_reset();
    @(negedge clock);
    enq_ptr           = 4'd3;
    head_commit_valid = 1'b1;
    head_req_ready    = 1'b1;
    head_resp_valid   = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    tests++;
    if ({deq_ptr, count, head_req_valid} !== {4'd1, 4'd2, 1'b1}) begin
      fails++;
      $display("FAIL ovl_pre: ptr=%0d cnt=%0d req=%b want 1 2 1",
               deq_ptr, count, head_req_valid);
    end
    @(negedge clock);
    enq_ptr = 4'd4;
    #1;
    tests++;
    if (deq_fire !== 1'b1) begin
      fails++;
      $display("FAIL ovl_fire: fire=%b want 1", deq_fire);
    end
    @(negedge clock);
    head_commit_valid = 1'b0;
    #1;
    tests++;
    if ({deq_ptr, count, empty, full} !== {4'd2, 4'd2, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL ovl_post: ptr=%0d cnt=%0d e=%b f=%b want 2 2 0 0",
               deq_ptr, count, empty, full);
    end
    enq_ptr = 4'd2;
    #1;
    tests++;
    if ({count, empty} !== {4'd0, 1'b1}) begin
      fails++;
      $display("FAIL flush: cnt=%0d e=%b want 0 1", count, empty);
    end
    head_commit_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if ({head_req_valid, deq_fire, deq_ptr} !== {1'b0, 1'b0, 4'd2}) begin
      fails++;
      $display("FAIL flush_idle: req=%b fire=%b ptr=%0d want 0 0 2",
               head_req_valid, deq_fire, deq_ptr);
    end
    head_commit_valid = 1'b0;
    head_resp_valid   = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    @(negedge clock);
    enq_ptr           = 4'b1000;
    head_commit_valid = 1'b1;
    head_req_ready    = 1'b1;
    head_resp_valid   = 1'b1;
    repeat (15) @(negedge clock);
    head_resp_valid = 1'b0;
    #1;
    tests++;
    if ({deq_ptr, deq_ptr_oh} !== {4'd5, 8'b0010_0000}) begin
      fails++;
      $display("FAIL rst_pre: ptr=%0d oh=%b want 5 00100000",
               deq_ptr, deq_ptr_oh);
    end
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if ({head_req_valid, deq_fire, deq_ptr} !== {1'b0, 1'b0, 4'd5}) begin
      fails++;
      $display("FAIL rst_wait: req=%b fire=%b ptr=%0d want 0 0 5",
               head_req_valid, deq_fire, deq_ptr);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({deq_ptr, deq_ptr_oh, head_req_valid} !== {4'd0, 8'b1, 1'b0}) begin
      fails++;
      $display("FAIL rst_async: ptr=%0d oh=%b req=%b want 0 1 0",
               deq_ptr, deq_ptr_oh, head_req_valid);
    end
    @(negedge clock);
    reset             = 1'b0;
    head_commit_valid = 1'b0;
    head_resp_valid   = 1'b1;
    #1;
    tests++;
    if ({deq_fire, deq_ptr} !== {1'b0, 4'd0}) begin
      fails++;
      $display("FAIL rst_late_resp: fire=%b ptr=%0d want 0 0",
               deq_fire, deq_ptr);
    end
    repeat (2) @(negedge clock);
    #1;
    tests++;
    if ({deq_fire, deq_ptr, head_req_valid} !== {1'b0, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL rst_idle: fire=%b ptr=%0d req=%b want 0 0 0",
               deq_fire, deq_ptr, head_req_valid);
    end
    head_resp_valid = 1'b0;
  endtask

  initial begin
    tests             = 0;
    fails             = 0;
    reset             = 1'b1;
    enq_ptr           = 4'd0;
    head_commit_valid = 1'b0;
    head_req_ready    = 1'b0;
    head_resp_valid   = 1'b0;
    test_reset();
    test_single_drain();
    test_wrap_full();
    test_backpressure();
    test_overlap_flush();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
